// File: rtl/mxint_accumulator_normalizer.sv
// Three-stage MxInt block re-normalizer: common headroom, left shift, round/truncate, exponent rebias+clamp.
// Define MXINT_NORMALIZER_ROUND_EN for round-half-up; the default build truncates (arithmetic floor).
module mxint_accumulator_normalizer #(
  parameter int DATA_IN_0_PRECISION_0  = 20,
  parameter int DATA_IN_0_PRECISION_1  = 5,
  parameter int DATA_OUT_0_PRECISION_0 = 8,
  parameter int DATA_OUT_0_PRECISION_1 = 4,
  parameter int BLOCK_SIZE             = 4
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [DATA_IN_0_PRECISION_0*BLOCK_SIZE-1:0]        mdata_in_0,
  input  logic [DATA_IN_0_PRECISION_1-1:0]                   edata_in_0,
  input  logic                                               data_in_0_valid,
  output logic                                               data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0*BLOCK_SIZE-1:0]       mdata_out_0,
  output logic [DATA_OUT_0_PRECISION_1-1:0]                  edata_out_0,
  output logic                                               data_out_0_valid,
  input  logic                                               data_out_0_ready
);

  localparam int WI   = DATA_IN_0_PRECISION_0;
  localparam int EI   = DATA_IN_0_PRECISION_1;
  localparam int WO   = DATA_OUT_0_PRECISION_0;
  localparam int EO   = DATA_OUT_0_PRECISION_1;
  localparam int BS   = BLOCK_SIZE;
  localparam int LZW  = (WI > 2) ? $clog2(WI) : 1;
  localparam int XW   = EI + LZW + 2;
  localparam int EMAX = (1 << EO) - 1;
`ifdef MXINT_NORMALIZER_ROUND_EN
  localparam int KW   = WO + 1;
`else
  localparam int KW   = WO;
`endif

  localparam logic signed [XW-1:0] BIAS_I = XW'((1 << (EI - 1)) - 1);
  localparam logic signed [XW-1:0] BIAS_O = XW'((1 << (EO - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX_X = XW'(EMAX);
  localparam logic [WO-1:0]        MAX_M  = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0]        MIN_M  = {1'b1, {(WO-1){1'b0}}};

  // Stage load enables: a stage loads when it is empty or its contents move on.
  logic s1_v_q, s2_v_q, s3_v_q;
  logic en1, en2, en3;

  assign en3             = !s3_v_q || data_out_0_ready;
  assign en2             = !s2_v_q || en3;
  assign en1             = !s1_v_q || en2;
  assign data_in_0_ready = en1;

  function automatic logic [LZW-1:0] headroom(input logic [WI-1:0] m);
    logic [LZW-1:0] cnt;
    logic           stop;
    cnt  = '0;
    stop = 1'b0;
    for (int b = WI - 2; b >= 0; b--) begin
      if (!stop && (m[b] == m[WI-1])) cnt = cnt + LZW'(1);
      else stop = 1'b1;
    end
    return cnt;
  endfunction

  // ---------------- S1: capture input, per-element headroom ----------------
  logic [WI-1:0]  s1_m_q  [BS];
  logic [LZW-1:0] s1_lz_q [BS];
  logic [LZW-1:0] s1_lz_d [BS];
  logic [EI-1:0]  s1_e_q;

  always_comb begin
    for (int i = 0; i < BS; i++) begin
      s1_lz_d[i] = headroom(mdata_in_0[i*WI +: WI]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q <= 1'b0;
      s1_e_q <= '0;
      for (int i = 0; i < BS; i++) begin
        s1_m_q[i]  <= '0;
        s1_lz_q[i] <= '0;
      end
    end else if (en1) begin
      s1_v_q <= data_in_0_valid;
      if (data_in_0_valid) begin
        s1_e_q <= edata_in_0;
        for (int i = 0; i < BS; i++) begin
          s1_m_q[i]  <= mdata_in_0[i*WI +: WI];
          s1_lz_q[i] <= s1_lz_d[i];
        end
      end
    end
  end

  // ---------------- S2: block shift, normalize ----------------
  // Only the top KW bits of each normalized mantissa are kept (plus the round bit when rounding).
  logic [LZW-1:0] s2_s_d;
  logic [KW-1:0]  s2_c_d  [BS];
  logic [BS-1:0]  s2_nz_d;
  logic [KW-1:0]  s2_c_q  [BS];
  logic [BS-1:0]  s2_nz_q;
  logic [LZW-1:0] s2_s_q;
  logic [EI-1:0]  s2_e_q;

  always_comb begin
    s2_s_d  = s1_lz_q[0];
    s2_nz_d = '0;
    for (int i = 0; i < BS; i++) begin
      if (s1_lz_q[i] < s2_s_d) s2_s_d = s1_lz_q[i];
      s2_nz_d[i] = (s1_m_q[i] != '0);
    end
    for (int i = 0; i < BS; i++) begin
      s2_c_d[i] = KW'(({s1_m_q[i], 1'b0} << s2_s_d) >> (WI + 1 - KW));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_v_q  <= 1'b0;
      s2_s_q  <= '0;
      s2_e_q  <= '0;
      s2_nz_q <= '0;
      for (int i = 0; i < BS; i++) s2_c_q[i] <= '0;
    end else if (en2) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_s_q  <= s2_s_d;
        s2_e_q  <= s1_e_q;
        s2_nz_q <= s2_nz_d;
        for (int i = 0; i < BS; i++) s2_c_q[i] <= s2_c_d[i];
      end
    end
  end

  // ---------------- S3: round/saturate, rebias and clamp exponent ----------------
  logic signed [XW-1:0] x;
  logic [WO:0]          cand;
  logic [WO-1:0]        sat;
  logic [WO*BS-1:0]     s3_m_d;
  logic [EO-1:0]        s3_e_d;
  logic [WO*BS-1:0]     s3_m_q;
  logic [EO-1:0]        s3_e_q;

  always_comb begin
    x      = $signed(XW'(s2_e_q)) - $signed(XW'(s2_s_q)) - BIAS_I + BIAS_O;
    cand   = '0;
    sat    = '0;
    s3_m_d = '0;
    s3_e_d = '0;
    for (int i = 0; i < BS; i++) begin
`ifdef MXINT_NORMALIZER_ROUND_EN
      cand = {s2_c_q[i][KW-1], s2_c_q[i][KW-1:1]} + (WO+1)'(s2_c_q[i][0]);
`else
      cand = {s2_c_q[i][KW-1], s2_c_q[i]};
`endif
      if (cand[WO] != cand[WO-1]) sat = cand[WO] ? MIN_M : MAX_M;
      else sat = cand[WO-1:0];

      if (!(|s2_nz_q) || (x < 0)) begin
        s3_m_d[i*WO +: WO] = '0;
      end else if (x > EMAX_X) begin
        if (!s2_nz_q[i]) s3_m_d[i*WO +: WO] = '0;
        else s3_m_d[i*WO +: WO] = s2_c_q[i][KW-1] ? MIN_M : MAX_M;
      end else begin
        s3_m_d[i*WO +: WO] = sat;
      end
    end

    if (!(|s2_nz_q) || (x < 0)) s3_e_d = '0;
    else if (x > EMAX_X) s3_e_d = EO'(EMAX);
    else s3_e_d = x[EO-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_v_q <= 1'b0;
      s3_m_q <= '0;
      s3_e_q <= '0;
    end else if (en3) begin
      s3_v_q <= s2_v_q;
      if (s2_v_q) begin
        s3_m_q <= s3_m_d;
        s3_e_q <= s3_e_d;
      end
    end
  end

  assign mdata_out_0      = s3_m_q;
  assign edata_out_0      = s3_e_q;
  assign data_out_0_valid = s3_v_q;

endmodule
